adder32_part_err_monitor: RTL and testbench

- Sequential quality-of-result monitor placed directly downstream of an approximated adder32 partition (9-in/5-out, BMF-factored).
- Consumes a stream of paired exact and approximate partition outputs for the same input vector.
- Accumulates error statistics over a programmed number of samples, then holds them for readout by the exploration flow.
- Used to score candidate factorization degrees (k) in hardware or emulation.

---
 rtl/adder32_part_err_monitor_if.sv | 33 +++
 rtl/adder32_part_err_monitor.sv | 156 +++++++++++++++
 tb/tb_adder32_part_err_monitor.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/adder32_part_err_monitor_if.sv
// Stream and readout bundle between the exploration driver and the
// partition error monitor.
interface adder32_part_err_monitor_if #(
    parameter int W     = 5,
    parameter int CNT_W = 16,
    parameter int ACC_W = 24
);
    logic             start;
    logic [CNT_W-1:0] num_samples;
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     exact_po;
    logic [W-1:0]     approx_po;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] sample_cnt;
    logic [CNT_W-1:0] err_cnt;
    logic [ACC_W-1:0] ham_sum;
    logic [ACC_W-1:0] abs_err_sum;
    logic [W-1:0]     max_abs_err;

    modport master (
        output start, num_samples, in_valid, exact_po, approx_po,
        input  in_ready, busy, done, sample_cnt, err_cnt, ham_sum,
               abs_err_sum, max_abs_err
    );

    modport slave (
        input  start, num_samples, in_valid, exact_po, approx_po,
        output in_ready, busy, done, sample_cnt, err_cnt, ham_sum,
               abs_err_sum, max_abs_err
    );
endinterface

// File: rtl/adder32_part_err_monitor.sv
// Quality-of-result monitor: accumulates error statistics between exact and
// approximate adder32 partition outputs over a programmed number of samples.
module adder32_part_err_monitor #(
    parameter int W     = 5,
    parameter int CNT_W = 16,
    parameter int ACC_W = 24
) (
    input  logic                        clk,
    input  logic                        rst,
    adder32_part_err_monitor_if.slave   bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic             drain_q, drain_d;
    logic [CNT_W-1:0] target_q, target_d;
    logic [CNT_W-1:0] sample_cnt_q, sample_cnt_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic [ACC_W-1:0] ham_sum_q, ham_sum_d;
    logic [ACC_W-1:0] abs_err_sum_q, abs_err_sum_d;
    logic [W-1:0]     max_abs_err_q, max_abs_err_d;
    logic             s1_valid_q, s1_valid_d;
    logic [W-1:0]     s1_exact_q, s1_exact_d;
    logic [W-1:0]     s1_approx_q, s1_approx_d;

    logic             in_ready;
    logic             accept;
    logic [W-1:0]     diff;
    logic [W-1:0]     ae;
    logic [ACC_W-1:0] pop;
    logic [ACC_W:0]   ham_ext;
    logic [ACC_W:0]   abs_ext;

    // S1 datapath: sums carry one extra bit so saturation is a carry test.
    always_comb begin
        diff = s1_exact_q ^ s1_approx_q;
        pop  = '0;
        for (int unsigned i = 0; i < W; i++) begin
            pop = pop + ACC_W'(diff[i]);
        end
        ae      = (s1_exact_q >= s1_approx_q) ? (s1_exact_q - s1_approx_q)
                                              : (s1_approx_q - s1_exact_q);
        ham_ext = {1'b0, ham_sum_q} + {1'b0, pop};
        abs_ext = {1'b0, abs_err_sum_q} + (ACC_W+1)'(ae);
    end

    assign in_ready = (state_q == S_RUN) && (sample_cnt_q < target_q);
    assign accept   = in_ready && bus.in_valid;

    always_comb begin
        state_d       = state_q;
        drain_d       = drain_q;
        target_d      = target_q;
        sample_cnt_d  = sample_cnt_q;
        err_cnt_d     = err_cnt_q;
        ham_sum_d     = ham_sum_q;
        abs_err_sum_d = abs_err_sum_q;
        max_abs_err_d = max_abs_err_q;
        s1_valid_d    = accept;
        s1_exact_d    = s1_exact_q;
        s1_approx_d   = s1_approx_q;

        if (accept) begin
            s1_exact_d  = bus.exact_po;
            s1_approx_d = bus.approx_po;
        end

        if (s1_valid_q) begin
            if ((diff != '0) && (err_cnt_q != '1)) begin
                err_cnt_d = err_cnt_q + CNT_W'(1);
            end
            ham_sum_d     = ham_ext[ACC_W] ? '1 : ham_ext[ACC_W-1:0];
            abs_err_sum_d = abs_ext[ACC_W] ? '1 : abs_ext[ACC_W-1:0];
            if (ae > max_abs_err_q) begin
                max_abs_err_d = ae;
            end
        end

        case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    target_d      = bus.num_samples;
                    sample_cnt_d  = '0;
                    err_cnt_d     = '0;
                    ham_sum_d     = '0;
                    abs_err_sum_d = '0;
                    max_abs_err_d = '0;
                    drain_d       = 1'b0;
                    state_d       = (bus.num_samples == '0) ? S_DRAIN : S_RUN;
                end
            end
            S_RUN: begin
                if (accept) begin
                    sample_cnt_d = sample_cnt_q + CNT_W'(1);
                    if ((sample_cnt_q + CNT_W'(1)) == target_q) begin
                        state_d = S_DRAIN;
                        drain_d = 1'b0;
                    end
                end
            end
            S_DRAIN: begin
                // Two cycles: one for S1 to retire, one to publish done.
                if (drain_q) begin
                    state_d = S_DONE;
                end else begin
                    drain_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            drain_q       <= 1'b0;
            target_q      <= '0;
            sample_cnt_q  <= '0;
            err_cnt_q     <= '0;
            ham_sum_q     <= '0;
            abs_err_sum_q <= '0;
            max_abs_err_q <= '0;
            s1_valid_q    <= 1'b0;
            s1_exact_q    <= '0;
            s1_approx_q   <= '0;
        end else begin
            state_q       <= state_d;
            drain_q       <= drain_d;
            target_q      <= target_d;
            sample_cnt_q  <= sample_cnt_d;
            err_cnt_q     <= err_cnt_d;
            ham_sum_q     <= ham_sum_d;
            abs_err_sum_q <= abs_err_sum_d;
            max_abs_err_q <= max_abs_err_d;
            s1_valid_q    <= s1_valid_d;
            s1_exact_q    <= s1_exact_d;
            s1_approx_q   <= s1_approx_d;
        end
    end

    assign bus.in_ready    = in_ready;
    assign bus.busy        = (state_q == S_RUN) || (state_q == S_DRAIN);
    assign bus.done        = (state_q == S_DONE);
    assign bus.sample_cnt  = sample_cnt_q;
    assign bus.err_cnt     = err_cnt_q;
    assign bus.ham_sum     = ham_sum_q;
    assign bus.abs_err_sum = abs_err_sum_q;
    assign bus.max_abs_err = max_abs_err_q;

endmodule

// File: tb/tb_adder32_part_err_monitor.sv
// Directed bench: two monitors (ACC_W=24 and ACC_W=6) see identical stimulus;
// per-run expected statistics are queued and compared when done rises.
module tb_adder32_part_err_monitor;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] num_samples;
    logic        in_valid;
    logic [4:0]  exact_po;
    logic [4:0]  approx_po;

    always #5 clk = ~clk;

    adder32_part_err_monitor_if #(.W(5), .CNT_W(16), .ACC_W(24)) b0 ();
    adder32_part_err_monitor_if #(.W(5), .CNT_W(16), .ACC_W(6))  b1 ();

    assign b0.start = start;       assign b1.start = start;
    assign b0.num_samples = num_samples; assign b1.num_samples = num_samples;
    assign b0.in_valid = in_valid; assign b1.in_valid = in_valid;
    assign b0.exact_po = exact_po; assign b1.exact_po = exact_po;
    assign b0.approx_po = approx_po; assign b1.approx_po = approx_po;

    adder32_part_err_monitor #(.W(5), .CNT_W(16), .ACC_W(24)) u0 (
        .clk(clk), .rst(rst), .bus(b0.slave));
    adder32_part_err_monitor #(.W(5), .CNT_W(16), .ACC_W(6)) u1 (
        .clk(clk), .rst(rst), .bus(b1.slave));

    typedef struct {
        int sc;
        int ec;
        int ham;
        int ae;
        int mx;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    int vectors = 0;
    int miscompares = 0;
    int since = 0;
    int m_cnt, m_err, m_ham, m_abs, m_max;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    function automatic int sat(input int x, input int acc_w);
        int lim;
        lim = (1 << acc_w) - 1;
        return (x > lim) ? lim : x;
    endfunction

    task automatic tick();
        @(negedge clk);
        start    = 1'b0;
        in_valid = 1'b0;
        since++;
    endtask

    task automatic do_start(input int n);
        tick();
        start       = 1'b1;
        num_samples = n[15:0];
        m_cnt = 0; m_err = 0; m_ham = 0; m_abs = 0; m_max = 0;
        since = 0;
    endtask

    task automatic beat(input int e, input int a, input bit exp_acc);
        int d;
        tick();
        in_valid  = 1'b1;
        exact_po  = e[4:0];
        approx_po = a[4:0];
        check("d0.in_ready", {31'd0, b0.in_ready}, {31'd0, exp_acc});
        check("d1.in_ready", {31'd0, b1.in_ready}, {31'd0, exp_acc});
        if (exp_acc) begin
            d = (e >= a) ? e - a : a - e;
            m_cnt++;
            if (e != a) m_err++;
            m_ham += $countones(e ^ a);
            m_abs += d;
            if (d > m_max) m_max = d;
            since = 0;
        end
    endtask

    task automatic push_exp();
        q0.push_back('{m_cnt, m_err, sat(m_ham, 24), sat(m_abs, 24), m_max});
        q1.push_back('{m_cnt, m_err, sat(m_ham, 6), sat(m_abs, 6), m_max});
    endtask

    task automatic check_zero(input string tag);
        check({tag, ".d0.sample_cnt"}, 32'(b0.sample_cnt), 0);
        check({tag, ".d0.err_cnt"}, 32'(b0.err_cnt), 0);
        check({tag, ".d0.ham_sum"}, 32'(b0.ham_sum), 0);
        check({tag, ".d0.abs_err_sum"}, 32'(b0.abs_err_sum), 0);
        check({tag, ".d0.max_abs_err"}, 32'(b0.max_abs_err), 0);
        check({tag, ".d0.flags"}, {29'd0, b0.in_ready, b0.busy, b0.done}, 0);
        check({tag, ".d1.sample_cnt"}, 32'(b1.sample_cnt), 0);
        check({tag, ".d1.abs_err_sum"}, 32'(b1.abs_err_sum), 0);
        check({tag, ".d1.flags"}, {29'd0, b1.in_ready, b1.busy, b1.done}, 0);
    endtask

    task automatic wait_done(input string tag);
        exp_t e0, e1;
        int   guard;
        guard = 0;
        while (1) begin
            tick();
            guard++;
            if (b0.done === 1'b1 || guard > 40) break;
            check({tag, ".drain_busy"}, {31'd0, b0.busy}, 1);
            check({tag, ".drain_rdy"}, {31'd0, b0.in_ready}, 0);
        end
        check({tag, ".d0.done"}, {31'd0, b0.done}, 1);
        check({tag, ".d1.done"}, {31'd0, b1.done}, 1);
        check({tag, ".done_latency"}, since, 3);
        check({tag, ".busy_at_done"}, {31'd0, b0.busy}, 0);
        check({tag, ".sb_depth"}, q0.size() + q1.size(), 2);
        if (q0.size() > 0 && q1.size() > 0) begin
            e0 = q0.pop_front();
            e1 = q1.pop_front();
            check({tag, ".d0.sample_cnt"}, 32'(b0.sample_cnt), e0.sc);
            check({tag, ".d0.err_cnt"}, 32'(b0.err_cnt), e0.ec);
            check({tag, ".d0.ham_sum"}, 32'(b0.ham_sum), e0.ham);
            check({tag, ".d0.abs_err_sum"}, 32'(b0.abs_err_sum), e0.ae);
            check({tag, ".d0.max_abs_err"}, 32'(b0.max_abs_err), e0.mx);
            check({tag, ".d1.sample_cnt"}, 32'(b1.sample_cnt), e1.sc);
            check({tag, ".d1.err_cnt"}, 32'(b1.err_cnt), e1.ec);
            check({tag, ".d1.ham_sum"}, 32'(b1.ham_sum), e1.ham);
            check({tag, ".d1.abs_err_sum"}, 32'(b1.abs_err_sum), e1.ae);
            check({tag, ".d1.max_abs_err"}, 32'(b1.max_abs_err), e1.mx);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; in_valid = 1'b0;
        num_samples = '0; exact_po = '0; approx_po = '0;
        tick(); tick();
        check_zero("reset");
        rst = 1'b0;

        // 1: identical pairs, no error
        do_start(8);
        for (int i = 0; i < 8; i++) beat(5'h0B, 5'h0B, 1'b1);
        push_exp();
        wait_done("t1");

        // 2: single MSB error
        do_start(1);
        beat(5'b10001, 5'b00001, 1'b1);
        push_exp();
        wait_done("t2");

        // 3: gaps, then a beat beyond the target is refused
        do_start(3);
        tick();
        beat(3, 5, 1'b1);
        tick(); tick();
        beat(31, 0, 1'b1);
        tick();
        beat(7, 7, 1'b1);
        beat(9, 2, 1'b0);
        push_exp();
        wait_done("t3");
        check("t3.sample_cnt_hold", 32'(b0.sample_cnt), 3);

        // 4: zero-length run
        do_start(0);
        push_exp();
        wait_done("t4");

        // 5: saturation of the narrow accumulator
        do_start(4);
        beat(31, 0, 1'b1);
        beat(0, 31, 1'b1);
        beat(31, 0, 1'b1);
        beat(0, 31, 1'b1);
        push_exp();
        wait_done("t5");

        // 6: stray start in RUN, reset mid-run, rst beats start, then recovery
        do_start(5);
        beat(1, 2, 1'b1);
        tick();
        start = 1'b1; num_samples = 16'd1;
        check("t6.busy_stray", {31'd0, b0.busy}, 1);
        beat(4, 4, 1'b1);
        check("t6.cnt_before_rst", 32'(b0.sample_cnt), 1);
        tick();
        rst = 1'b1;
        tick();
        check_zero("t6.rst");
        start = 1'b1; num_samples = 16'd3;
        tick();
        rst = 1'b0;
        check_zero("t6.rst_start");
        do_start(1);
        beat(6, 3, 1'b1);
        push_exp();
        wait_done("t6");

        // random run with gaps, restarted straight from DONE
        do_start(20);
        for (int i = 0; i < 20; i++) begin
            if ($urandom_range(0, 3) == 0) tick();
            beat(int'($urandom_range(0, 31)), int'($urandom_range(0, 31)), 1'b1);
        end
        push_exp();
        wait_done("rand");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
